corescore_reset_seq: RTL and testbench
======================================

// Module: corescore_reset_seq
// PURPOSE
//  Reset sequencer downstream of the PLL clock generator. Runs in the generated core clock.
//  Turns the lock-derived reset into a clean, synchronised reset and releases the core array in
//  STAGES staggered groups, which limits the current step when many cores start together.
//  Optional watchdog re-runs the full sequence if software stops kicking it.
// PARAMETERS
//  HOLD_CYCLES  16  cycles all resets stay asserted after the synchroniser releases (>=1)
//  STAGES       4   number of staggered reset groups (>=1)
//  STAGE_GAP    8   cycles between consecutive group releases (>=1)
//  WDOG_W       24  watchdog counter width; timeout = 2**WDOG_W-1 cycles
// PORTS
//  i_clk         in   1       core clock, output of the clock generator
//  i_rst_n       in   1       reset, asynchronous, active-low; the lock-derived reset drives it
//  i_soft_rst    in   1       synchronous level request; restarts the sequence
//  i_kick        in   1       watchdog kick, single-cycle pulse, RUN state only
//  o_rst         out  1       global reset, active-high
//  o_stage_rst   out  STAGES  per-group resets, active-high; bit 0 is released first
//  o_done        out  1       high when every group is released (state RUN)
//  o_wdog_fired  out  1       sticky; set when a watchdog timeout occurs
// BEHAVIOUR
//  Reset assertion is asynchronous. While i_rst_n=0 these values hold immediately:
//   o_rst=1, o_stage_rst=all 1, o_done=0, o_wdog_fired=0.
//   State=ASSERT. All counters are 0. Synchroniser flops are 0.
//  Deassertion passes through a 2-flop synchroniser (sync_n). sync_n goes to 1 on the 2nd i_clk edge
//   after i_rst_n rises. Edge numbering: edge 1 is the first edge that samples i_rst_n=1.
//  FSM: ASSERT -> HOLD -> STAGGER -> RUN.
//   ASSERT: all resets are high. Go to HOLD on the edge where sync_n=1 and i_soft_rst=0.
//   HOLD: count HOLD_CYCLES edges. On the last one, clear o_rst and o_stage_rst[0], then go to STAGGER.
//   STAGGER: o_stage_rst[k] clears exactly k*STAGE_GAP edges after o_stage_rst[0] clears.
//    After the last group clears, the next edge sets o_done=1 and enters RUN.
//    If STAGES=1, STAGGER lasts 1 edge.
//   RUN: all outputs are released and o_done=1.
//  Defaults, edges counted from edge 1:
//   o_rst and group 0 clear on edge 18. Groups 1/2/3 clear on edges 26/34/42. o_done rises on edge 43.
//  Soft reset: i_soft_rst=1 seen in any state sends the FSM to ASSERT on that edge.
//   On that edge: o_rst=1, all o_stage_rst=1, o_done=0, counters cleared.
//   The FSM stays in ASSERT while i_soft_rst=1. After it drops, the full HOLD/STAGGER sequence repeats.
//  Reset mid-sequence: i_rst_n=0 in any state behaves as a full async reset. Nothing partial survives.
//  Simultaneous events: i_soft_rst beats any watchdog timeout or kick in the same cycle.
//   A soft reset does not set o_wdog_fired.
//  Monotonic: o_stage_rst is a thermometer. Bit k is never 0 while bit k-1 is 1. o_rst == o_stage_rst[0].
//  All outputs are registered. No combinational path runs from any input to any output.
// CONFIGURATION
//  CORESCORE_RST_WDOG_EN defined:
//   The WDOG_W-bit counter is cleared in every state other than RUN.
//   In RUN it counts +1 per edge and is cleared by i_kick. The clear wins over the count in the same cycle.
//   When the counter reaches 2**WDOG_W-1 without a kick, the next edge acts as a one-cycle soft reset:
//    FSM goes to ASSERT, o_wdog_fired is set, and the sequence reruns.
//   o_wdog_fired stays 1 until i_rst_n=0. A soft reset does not clear it.
//  CORESCORE_RST_WDOG_EN undefined:
//   No counter is implemented. i_kick is ignored. o_wdog_fired is tied to 0. Ports are unchanged.
// TESTING
//  1. Power-up, defaults: release i_rst_n.
//     -> o_rst/stage0 fall on edge 18, stage1/2/3 on 26/34/42, o_done rises on 43.
//  2. Async reset in STAGGER: pull i_rst_n low mid-cycle at edge 30.
//     -> all o_stage_rst=1 and o_done=0 before the next edge. Release again -> timing of test 1.
//  3. Soft reset in RUN: 3-cycle i_soft_rst pulse.
//     -> outputs reassert on the first edge. o_rst clears HOLD_CYCLES edges after the last edge with i_soft_rst=1.
//  4. Watchdog (macro defined, WDOG_W=4): reach RUN with no kicks.
//     -> ASSERT on edge 16 after RUN entry, o_wdog_fired=1, the sequence reruns.
//     Kicking every 10 cycles -> no reset ever.
//  5. Kick and soft reset in the same cycle (macro defined), with the counter at 14 in RUN.
//     -> soft reset occurs, o_wdog_fired stays 0.
//  6. Macro undefined, WDOG_W=4: 100 cycles in RUN with no kicks -> o_done stays 1, o_wdog_fired=0.
//     STAGES=1 run -> o_done rises 1 edge after o_rst clears.

Source files
------------

// File: rtl/corescore_reset_seq.sv
// Staggered reset sequencer for the core array: synchronises the lock-derived reset, holds, then
// releases STAGES groups STAGE_GAP cycles apart. `define CORESCORE_RST_WDOG_EN adds the watchdog.
module corescore_reset_seq #(
    parameter int HOLD_CYCLES = 16,
    parameter int STAGES      = 4,
    parameter int STAGE_GAP   = 8,
    parameter int WDOG_W      = 24
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_soft_rst,
    input  logic              i_kick,
    output logic              o_rst,
    output logic [STAGES-1:0] o_stage_rst,
    output logic              o_done,
    output logic              o_wdog_fired
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int GAP_W  = $clog2(STAGE_GAP + 1);
    localparam int IDX_W  = $clog2(STAGES + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0]  IDX_END   = IDX_W'(STAGES);

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_HOLD,
        ST_STAGGER,
        ST_RUN
    } state_t;

    state_t             state_q, state_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [STAGES-1:0]  stage_q, stage_d;
    logic               done_q, done_d;
    logic [1:0]         sync_q;
    logic               sync_n;
    logic               wdog_expired;

    // Two-flop release synchroniser; assertion stays asynchronous through the flop resets.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign sync_n = sync_q[1];

`ifdef CORESCORE_RST_WDOG_EN
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              fired_q;

    // A kick on the terminal count still rescues the core.
    assign wdog_expired = (state_q == ST_RUN) && !i_kick && (wdog_q == '1);

    always_comb begin
        wdog_d = '0;
        if (state_q == ST_RUN && state_d == ST_RUN && !i_kick) begin
            wdog_d = wdog_q + WDOG_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wdog_q  <= '0;
            fired_q <= 1'b0;
        end else begin
            wdog_q  <= wdog_d;
            fired_q <= fired_q | (wdog_expired & ~i_soft_rst);
        end
    end

    assign o_wdog_fired = fired_q;
`else
    logic [WDOG_W-1:0] wdog_unused;

    assign wdog_unused  = {WDOG_W{i_kick}};
    assign wdog_expired = 1'b0;
    assign o_wdog_fired = 1'b0;
`endif

    always_comb begin
        // NOTE: every comb output gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        idx_d      = idx_q;

        case (state_q)
            ST_ASSERT: begin
                if (sync_n) begin
                    // The entry edge is the first of the HOLD_CYCLES hold edges.
                    if (HOLD_CYCLES == 1) begin
                        state_d   = ST_STAGGER;
                        idx_d     = IDX_W'(1);
                        gap_cnt_d = '0;
                    end else begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = HOLD_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d   = ST_STAGGER;
                    idx_d     = IDX_W'(1);
                    gap_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            ST_STAGGER: begin
                // idx is the lowest group still held in reset.
                if (idx_q == IDX_END) begin
                    state_d = ST_RUN;
                end else if (gap_cnt_q == GAP_LAST) begin
                    idx_d     = idx_q + IDX_W'(1);
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            ST_RUN: begin
                if (wdog_expired) begin
                    state_d = ST_ASSERT;
                end
            end
            default: state_d = ST_ASSERT;
        endcase

        if (i_soft_rst) begin
            state_d = ST_ASSERT;
        end

        if (state_d == ST_ASSERT) begin
            hold_cnt_d = '0;
            gap_cnt_d  = '0;
            idx_d      = '0;
        end
    end

    // Outputs decode from the next state so they are registered yet change on the same edge.
    always_comb begin
        stage_d = '1;
        done_d  = 1'b0;
        case (state_d)
            ST_STAGGER: begin
                for (int k = 0; k < STAGES; k++) begin
                    stage_d[k] = (IDX_W'(k) >= idx_d);
                end
            end
            ST_RUN: begin
                stage_d = '0;
                done_d  = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_ASSERT;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
            idx_q      <= '0;
            stage_q    <= '1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            idx_q      <= idx_d;
            stage_q    <= stage_d;
            done_q     <= done_d;
        end
    end

    assign o_stage_rst = stage_q;
    assign o_rst       = stage_q[0];
    assign o_done      = done_q;

endmodule

// File: tb/tb_corescore_reset_seq.sv
// Randomised self-checking bench for corescore_reset_seq: two configurations against a model that
// tracks "edges since the sequence started" and "cycles since last kick".
module tb_corescore_reset_seq;

    localparam int H0 = 16, S0 = 4, G0 = 8;
    localparam int H1 = 2,  S1 = 1, G1 = 3;
    localparam int W    = 4;
    localparam int WMAX = (1 << W) - 1;
`ifdef CORESCORE_RST_WDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    logic       i_clk = 1'b0;
    logic       i_rst_n, i_soft_rst, i_kick;
    logic       o_rst0, o_done0, o_fired0;
    logic [3:0] o_stage0;
    logic       o_rst1, o_done1, o_fired1;
    logic [0:0] o_stage1;

    always #5 i_clk = ~i_clk;

    corescore_reset_seq #(.HOLD_CYCLES(H0), .STAGES(S0), .STAGE_GAP(G0), .WDOG_W(W)) u_dut0 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_soft_rst(i_soft_rst), .i_kick(i_kick),
        .o_rst(o_rst0), .o_stage_rst(o_stage0), .o_done(o_done0), .o_wdog_fired(o_fired0)
    );

    corescore_reset_seq #(.HOLD_CYCLES(H1), .STAGES(S1), .STAGE_GAP(G1), .WDOG_W(W)) u_dut1 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_soft_rst(i_soft_rst), .i_kick(i_kick),
        .o_rst(o_rst1), .o_stage_rst(o_stage1), .o_done(o_done1), .o_wdog_fired(o_fired1)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model state: m_t = edges since HOLD entry (entry edge = 1), -1 while held in ASSERT.
    int m_t[2];
    int m_wd[2];
    bit m_fired[2];
    int m_hi;

    function automatic int hp(input int d); return (d == 0) ? H0 : H1; endfunction
    function automatic int sp(input int d); return (d == 0) ? S0 : S1; endfunction
    function automatic int gp(input int d); return (d == 0) ? G0 : G1; endfunction
    function automatic int done_t(input int d); return hp(d) + (sp(d) - 1) * gp(d) + 1; endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_hi = 0;
        for (int d = 0; d < 2; d++) begin
            m_t[d]     = -1;
            m_wd[d]    = 0;
            m_fired[d] = 1'b0;
        end
    endtask

    task automatic model_edge();
        bit sync_ok;
        sync_ok = (m_hi >= 2);
        if (m_hi < 2) m_hi++;
        for (int d = 0; d < 2; d++) begin
            if (i_soft_rst) begin
                m_t[d]  = -1;
                m_wd[d] = 0;
            end else if (m_t[d] < 0) begin
                if (sync_ok) m_t[d] = 1;
            end else if (m_t[d] >= done_t(d)) begin
                if (i_kick) begin
                    m_wd[d] = 0;
                end else if (m_wd[d] >= WMAX) begin
                    if (WDOG_ON) begin
                        m_fired[d] = 1'b1;
                        m_t[d]     = -1;
                        m_wd[d]    = 0;
                    end
                end else begin
                    m_wd[d]++;
                end
            end else begin
                m_t[d]++;
            end
        end
    endtask

    function automatic logic [31:0] exp_vec(input int d);
        logic [3:0] st;
        logic       r, dn;
        st = '0;
        for (int k = 0; k < sp(d); k++) st[k] = (m_t[d] < hp(d) + k * gp(d));
        r  = (m_t[d] < hp(d));
        dn = (m_t[d] >= done_t(d));
        if (d == 0) return {25'd0, r, st, dn, m_fired[0]};
        return {28'd0, r, st[0], dn, m_fired[1]};
    endfunction

    task automatic compare_all();
        check("dut0_outputs", {25'd0, o_rst0, o_stage0, o_done0, o_fired0}, exp_vec(0));
        check("dut1_outputs", {28'd0, o_rst1, o_stage1, o_done1, o_fired1}, exp_vec(1));
    endtask

    task automatic tick();
        @(posedge i_clk);
        cyc++;
        if (i_rst_n) model_edge();
        @(negedge i_clk);
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Pulled low between edges; outputs must already be in reset before the next edge.
    task automatic do_async_reset();
        i_rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
    endtask

    task automatic run_from_release(input int n, input bit measure);
        int e_rst, e_s1, e_s2, e_s3, e_done, e1_rst, e1_done;
        e_rst = 0; e_s1 = 0; e_s2 = 0; e_s3 = 0; e_done = 0; e1_rst = 0; e1_done = 0;
        i_rst_n = 1'b1;
        for (int e = 1; e <= n; e++) begin
            tick();
            if (e_rst == 0 && !o_rst0)      e_rst = e;
            if (e_s1 == 0 && !o_stage0[1])  e_s1 = e;
            if (e_s2 == 0 && !o_stage0[2])  e_s2 = e;
            if (e_s3 == 0 && !o_stage0[3])  e_s3 = e;
            if (e_done == 0 && o_done0)     e_done = e;
            if (e1_rst == 0 && !o_rst1)     e1_rst = e;
            if (e1_done == 0 && o_done1)    e1_done = e;
        end
        if (measure) begin
            check("pwr_rst_edge",    e_rst,  18);
            check("pwr_stage1_edge", e_s1,   26);
            check("pwr_stage2_edge", e_s2,   34);
            check("pwr_stage3_edge", e_s3,   42);
            check("pwr_done_edge",   e_done, 43);
            check("one_stage_done_gap", e1_done - e1_rst, 1);
        end
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            tick();
            ok = o_done0;
        end
        check("done_reached", ok, 1);
    endtask

    initial begin
        int e, low, drop;
        i_rst_n = 1'b0; i_soft_rst = 1'b0; i_kick = 1'b0;
        model_reset();
        ticks(3);

        // Power-up timing, then an async reset caught mid-STAGGER.
        run_from_release(45, 1'b1);
        do_async_reset();
        ticks(2);
        run_from_release(30, 1'b0);
        do_async_reset();
        ticks(2);
        run_from_release(45, 1'b1);

        // Three-cycle soft reset from RUN.
        i_soft_rst = 1'b1;
        ticks(3);
        i_soft_rst = 1'b0;
        e = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (e == 0 && !o_rst0) e = i;
        end
        check("soft_release_edge", e, H0);
        wait_done();

        // Regular kicks keep the core running.
        low = 0;
        for (int i = 0; i < 100; i++) begin
            i_kick = (i % 10 == 0);
            tick();
            i_kick = 1'b0;
            if (!o_done0) low++;
        end
        check("kicked_no_reset", low, 0);

        // Kick and soft reset together with the idle count at 14.
        do_async_reset();
        ticks(2);
        i_rst_n = 1'b1;
        wait_done();
        ticks(14);
        i_soft_rst = 1'b1;
        i_kick = 1'b1;
        tick();
        i_soft_rst = 1'b0;
        i_kick = 1'b0;
        check("kick_soft_assert", o_done0, 0);
        check("kick_soft_no_fire", o_fired0, 0);

        // Unkicked RUN: watchdog fires on edge 16 if built in, otherwise nothing happens.
        wait_done();
        drop = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (drop == 0 && !o_done0) drop = i;
        end
        check("wdog_drop_edge", drop, WDOG_ON ? 16 : 0);
        check("wdog_fired", o_fired0, WDOG_ON);

        // Random soft resets, kicks and async resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_async_reset();
                ticks($urandom_range(0, 3));
                i_rst_n = 1'b1;
            end
            i_soft_rst = ($urandom_range(0, 99) < 2);
            i_kick     = ($urandom_range(0, 99) < 7);
            tick();
        end
        i_soft_rst = 1'b0;
        i_kick = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
